key_ascii_queue: RTL

//  Sits between the keyboard PS/2 byte receiver and the memory-mapped key register.

---
 rtl/key_ascii_queue_if.sv | 35 +++
 rtl/key_ascii_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_ascii_queue_if.sv
// Groups the scancode input, pop request and queue-head outputs of key_ascii_queue.
// Latency: none; this is wiring only.
// Backpressure: none; the queue drops characters when full and reports it through overflow.
interface key_ascii_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          scan_valid;
    logic [7:0]    scan_code;
    logic          clean_key_buffer;
    logic [7:0]    pressed_key;
    logic [CW-1:0] key_count;
    logic          overflow;

    // Keyboard receiver and memory block side
    modport master (
        output scan_valid,
        output scan_code,
        output clean_key_buffer,
        input  pressed_key,
        input  key_count,
        input  overflow
    );

    // Queue side
    modport slave (
        input  scan_valid,
        input  scan_code,
        input  clean_key_buffer,
        output pressed_key,
        output key_count,
        output overflow
    );
endinterface

// File: rtl/key_ascii_queue.sv
// PS/2 set-2 scancode decoder with Shift/Caps tracking, ASCII translation and a character FIFO.
// Latency: a make byte sampled at edge N is written at edge N+1 and visible after that edge.
// Backpressure: none upstream; a character arriving on a full queue with no pop is dropped, overflow sticks.
module key_ascii_queue #(
    parameter int DEPTH = 16  // power of two, at least 2
) (
    input  logic             CLK,
    input  logic             reset,
    key_ascii_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          shift_l_q, shift_l_d;
    logic          shift_r_q, shift_r_d;
    logic          caps_q, caps_d;
    logic          caps_held_q, caps_held_d;
    logic          enq_vld_q, enq_vld_d;
    logic [7:0]    enq_dat_q, enq_dat_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [DEPTH];

    logic          shift;
    logic          xlat_vld;
    logic [7:0]    xlat_dat;
    logic          is_letter;
    logic [7:0]    letter_lc;
    logic          do_pop;
    logic          do_write;
    logic          full;

    assign shift = shift_l_q | shift_r_q;

    // Translate the current byte to ASCII as if it were a non-modifier make code
    always_comb begin
        xlat_vld  = 1'b1;
        xlat_dat  = 8'h00;
        is_letter = 1'b0;
        letter_lc = 8'h00;
        case (bus.scan_code)
            8'h1C: begin is_letter = 1'b1; letter_lc = 8'h61; end  // a
            8'h32: begin is_letter = 1'b1; letter_lc = 8'h62; end  // b
            8'h21: begin is_letter = 1'b1; letter_lc = 8'h63; end  // c
            8'h23: begin is_letter = 1'b1; letter_lc = 8'h64; end  // d
            8'h24: begin is_letter = 1'b1; letter_lc = 8'h65; end  // e
            8'h2B: begin is_letter = 1'b1; letter_lc = 8'h66; end  // f
            8'h34: begin is_letter = 1'b1; letter_lc = 8'h67; end  // g
            8'h33: begin is_letter = 1'b1; letter_lc = 8'h68; end  // h
            8'h43: begin is_letter = 1'b1; letter_lc = 8'h69; end  // i
            8'h3B: begin is_letter = 1'b1; letter_lc = 8'h6A; end  // j
            8'h42: begin is_letter = 1'b1; letter_lc = 8'h6B; end  // k
            8'h4B: begin is_letter = 1'b1; letter_lc = 8'h6C; end  // l
            8'h3A: begin is_letter = 1'b1; letter_lc = 8'h6D; end  // m
            8'h31: begin is_letter = 1'b1; letter_lc = 8'h6E; end  // n
            8'h44: begin is_letter = 1'b1; letter_lc = 8'h6F; end  // o
            8'h4D: begin is_letter = 1'b1; letter_lc = 8'h70; end  // p
            8'h15: begin is_letter = 1'b1; letter_lc = 8'h71; end  // q
            8'h2D: begin is_letter = 1'b1; letter_lc = 8'h72; end  // r
            8'h1B: begin is_letter = 1'b1; letter_lc = 8'h73; end  // s
            8'h2C: begin is_letter = 1'b1; letter_lc = 8'h74; end  // t
            8'h3C: begin is_letter = 1'b1; letter_lc = 8'h75; end  // u
            8'h2A: begin is_letter = 1'b1; letter_lc = 8'h76; end  // v
            8'h1D: begin is_letter = 1'b1; letter_lc = 8'h77; end  // w
            8'h22: begin is_letter = 1'b1; letter_lc = 8'h78; end  // x
            8'h35: begin is_letter = 1'b1; letter_lc = 8'h79; end  // y
            8'h1A: begin is_letter = 1'b1; letter_lc = 8'h7A; end  // z
            8'h45:   xlat_dat = shift ? 8'h29 : 8'h30;  // 0 )
            8'h16:   xlat_dat = shift ? 8'h21 : 8'h31;  // 1 !
            8'h1E:   xlat_dat = shift ? 8'h40 : 8'h32;  // 2 @
            8'h26:   xlat_dat = shift ? 8'h23 : 8'h33;  // 3 #
            8'h25:   xlat_dat = shift ? 8'h24 : 8'h34;  // 4 $
            8'h2E:   xlat_dat = shift ? 8'h25 : 8'h35;  // 5 %
            8'h36:   xlat_dat = shift ? 8'h5E : 8'h36;  // 6 ^
            8'h3D:   xlat_dat = shift ? 8'h26 : 8'h37;  // 7 &
            8'h3E:   xlat_dat = shift ? 8'h2A : 8'h38;  // 8 *
            8'h46:   xlat_dat = shift ? 8'h28 : 8'h39;  // 9 (
            8'h29:   xlat_dat = 8'h20;                  // space
            8'h5A:   xlat_dat = 8'h0A;                  // enter
            8'h66:   xlat_dat = 8'h08;                  // backspace
            8'h0D:   xlat_dat = 8'h09;                  // tab
            8'h76:   xlat_dat = 8'h1B;                  // escape
            default: xlat_vld = 1'b0;
        endcase
        if (is_letter) begin
            xlat_dat = (shift ^ caps_q) ? (letter_lc - 8'h20) : letter_lc;
        end
    end

    // Prefix-tracking decoder: update modifiers and stage one character for the FIFO
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        enq_vld_d   = 1'b0;
        enq_dat_d   = enq_dat_q;
        if (bus.scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.scan_code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (bus.scan_code == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else begin
                        case (bus.scan_code)
                            8'h12: shift_l_d = 1'b1;
                            8'h59: shift_r_d = 1'b1;
                            8'h58: begin
                                // typematic repeats of Caps Lock arrive with caps_held set
                                if (!caps_held_q) begin
                                    caps_d = ~caps_q;
                                end
                                caps_held_d = 1'b1;
                            end
                            default: begin
                                enq_vld_d = xlat_vld;
                                enq_dat_d = xlat_dat;
                            end
                        endcase
                    end
                end
                ST_BREAK: begin
                    case (bus.scan_code)
                        8'h12:   shift_l_d   = 1'b0;
                        8'h59:   shift_r_d   = 1'b0;
                        8'h58:   caps_held_d = 1'b0;
                        default: ;
                    endcase
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    // extended keys, including the E0 12 fake shift, have no effect
                    state_d = (bus.scan_code == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign full     = (count_q == CW'(DEPTH));
    assign do_pop   = bus.clean_key_buffer && (count_q != '0);
    // a pop in the same cycle frees the slot, so a full queue still accepts the write
    assign do_write = enq_vld_q && (!full || do_pop);

    // FIFO pointer, occupancy and sticky overflow bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_write && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_write && do_pop) begin
            count_d = count_q - 1'b1;
        end
        if (enq_vld_q && !do_write) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            enq_vld_q   <= 1'b0;
            enq_dat_q   <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            enq_vld_q   <= enq_vld_d;
            enq_dat_q   <= enq_dat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Character storage; contents are qualified by count_q so no reset is needed
    always_ff @(posedge CLK) begin
        if (!reset && do_write) begin
            mem_q[wr_ptr_q] <= enq_dat_q;
        end
    end

    assign bus.pressed_key = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.key_count   = count_q;
    assign bus.overflow    = overflow_q;
endmodule
